// File: rtl/booth_wallace_mul_frac_pipe_pkg.sv
// Shared widths, Q-format types and the signed/unsigned clamp used by the
// multi-lane fractional multiplier.
package mul_frac_pkg;
  localparam int INT_WIDTH  = 8;
  localparam int FRAC_WIDTH = 8;
  localparam int W          = INT_WIDTH + FRAC_WIDTH;
  localparam int PROD_W     = 2*W + 2;

  typedef logic [W-1:0]      q_t;
  typedef logic [PROD_W-1:0] prod_t;
  typedef struct packed {
    q_t   q;
    logic sat;
  } sat_res_t;

  localparam logic signed [PROD_W-1:0] S_MAX = {{(PROD_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] S_MIN = {{(PROD_W-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] U_MAX = {{(PROD_W-W){1'b0}}, {W{1'b1}}};

  // r is the already-scaled product; clamp it into the W-bit result range.
  function automatic sat_res_t sat_clamp(input prod_t r, input logic is_signed);
    sat_res_t res;
    logic signed [PROD_W-1:0] rs;
    rs      = r;
    res.q   = r[W-1:0];
    res.sat = 1'b0;
    if (is_signed) begin
      if (rs > S_MAX) begin
        res.q = {1'b0, {(W-1){1'b1}}}; res.sat = 1'b1;
      end else if (rs < S_MIN) begin
        res.q = {1'b1, {(W-1){1'b0}}}; res.sat = 1'b1;
      end
    end else if (rs > U_MAX) begin
      res.q = {W{1'b1}}; res.sat = 1'b1;
    end
    return res;
  endfunction
endpackage

// File: rtl/booth_wallace_mul_frac_pipe_if.sv
// Operand/result handshake bundle for the multi-lane fractional multiplier.
interface booth_wallace_mul_frac_pipe_if
  import mul_frac_pkg::*;
#(parameter int LANES = 4) ();
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_signed;
  q_t [LANES-1:0]        in_a;
  logic [LANES-1:0][W-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  q_t [LANES-1:0]        out_result;
  logic [LANES-1:0]      out_sat;

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, out_sat
  );
  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, out_sat
  );
endinterface

// File: rtl/booth_wallace_mul_frac_pipe_round_sat.sv
// Per-lane S2->S3 path: optional round-half-up, arithmetic scale to Q format, clamp.
// Rounding is built only when MUL_FRAC_ROUND_NEAREST_EN is defined.
module mul_frac_round_sat
  import mul_frac_pkg::*;
(
  input  prod_t p,
  input  logic  is_signed,
  output q_t    q,
  output logic  sat
);
  prod_t    pr, r;
  sat_res_t res;

`ifdef MUL_FRAC_ROUND_NEAREST_EN
  assign pr = p + prod_t'(1 << (FRAC_WIDTH-1));
`else
  assign pr = p;
`endif

  assign r   = prod_t'($signed(pr) >>> FRAC_WIDTH);
  assign res = sat_clamp(r, is_signed);
  assign q   = res.q;
  assign sat = res.sat;
endmodule

// File: rtl/booth_wallace_multiplier.sv
// Combinational signed multiplier: radix-4 Booth partial products reduced by
// a Wallace tree of 3:2 compressors, then one carry-propagate add.
module booth_wallace_multiplier #(
  parameter int WIDTH = 17
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  localparam int P  = 2*WIDTH;
  localparam int NG = (WIDTH+2)/2;

  function automatic int rows_after(input int n, input int lv);
    int r;
    r = n;
    for (int k = 0; k < lv; k++)
      if (r > 2) r = 2*(r/3) + r%3;
    return r;
  endfunction

  function automatic int levels(input int n);
    int r, l;
    r = n;
    l = 0;
    while (r > 2) begin
      r = 2*(r/3) + r%3;
      l++;
    end
    return l;
  endfunction

  localparam int LV = levels(NG);

  // All rows are kept at full product width, so carries out of the top are
  // simply discarded (arithmetic is modulo 2^P).
  for (genvar g = 0; g <= LV; g++) begin : lvl
    localparam int N = rows_after(NG, g);
    logic [P-1:0] r [N];
    if (g == 0) begin : g_pp
      logic [P-1:0]  ax;
      logic [2*NG:0] bx;
      assign ax = {{(P-WIDTH){a[WIDTH-1]}}, a};
      assign bx = {{(2*NG-WIDTH){b[WIDTH-1]}}, b, 1'b0};
      for (genvar i = 0; i < NG; i++) begin : g_dig
        logic [P-1:0] m;
        always_comb begin
          m = '0;
          case (bx[2*i+2:2*i])
            3'b001, 3'b010: m = ax;
            3'b011:         m = ax << 1;
            3'b100:         m = -(ax << 1);
            3'b101, 3'b110: m = -ax;
            default:        m = '0;
          endcase
        end
        assign r[i] = m << (2*i);
      end
    end else begin : g_csa
      localparam int NP = rows_after(NG, g-1);
      for (genvar j = 0; j < NP/3; j++) begin : g_fa
        logic [P-1:0] x, y, z;
        assign x = lvl[g-1].r[3*j];
        assign y = lvl[g-1].r[3*j+1];
        assign z = lvl[g-1].r[3*j+2];
        assign r[2*j]   = x ^ y ^ z;
        assign r[2*j+1] = ((x & y) | (x & z) | (y & z)) << 1;
      end
      for (genvar k = 0; k < NP%3; k++) begin : g_pass
        assign r[2*(NP/3)+k] = lvl[g-1].r[3*(NP/3)+k];
      end
    end
  end

  assign p = lvl[LV].r[0] + lvl[LV].r[1];
endmodule

// File: rtl/booth_wallace_mul_frac_pipe.sv
// Multi-lane 3-stage Q-format multiplier with valid/ready backpressure and saturation.
// Build option: MUL_FRAC_ROUND_NEAREST_EN selects round-half-up instead of truncation.
module booth_wallace_mul_frac_pipe
  import mul_frac_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  booth_wallace_mul_frac_pipe_if.slave  bus
);
  localparam int STAGES = 3;

  logic [STAGES:1]   vld_pipe;
  logic              adv1, adv2, adv3;
  q_t [LANES-1:0]    a1, b1;
  logic              sgn1, sgn2;
  prod_t [LANES-1:0] prod, p2;
  q_t [LANES-1:0]    rs_q;
  logic [LANES-1:0]  rs_sat;

  // A stage may load when it is empty or the stage after it is moving.
  assign adv3 = !vld_pipe[3] || bus.out_ready;
  assign adv2 = !vld_pipe[2] || adv3;
  assign adv1 = !vld_pipe[1] || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = vld_pipe[3];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W:0] ax, bx;
    assign ax = {sgn1 & a1[i][W-1], a1[i]};
    assign bx = {sgn1 & b1[i][W-1], b1[i]};

    booth_wallace_multiplier #(.WIDTH(W+1)) u_mul (
      .a (ax),
      .b (bx),
      .p (prod[i])
    );

    mul_frac_round_sat u_rs (
      .p         (p2[i]),
      .is_signed (sgn2),
      .q         (rs_q[i]),
      .sat       (rs_sat[i])
    );
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe       <= '0;
      a1             <= '0;
      b1             <= '0;
      sgn1           <= 1'b0;
      p2             <= '0;
      sgn2           <= 1'b0;
      bus.out_result <= '0;
      bus.out_sat    <= '0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) begin
          a1   <= bus.in_a;
          b1   <= bus.in_b;
          sgn1 <= bus.in_signed;
        end
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          p2   <= prod;
          sgn2 <= sgn1;
        end
      end
      if (adv3) begin
        vld_pipe[3] <= vld_pipe[2];
        if (vld_pipe[2]) begin
          bus.out_result <= rs_q;
          bus.out_sat    <= rs_sat;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_wallace_mul_frac_pipe.sv
// Scoreboard bench for booth_wallace_mul_frac_pipe: directed Q8.8 cases, random traffic
// under random backpressure, stall/stability, and reset with bundles in flight.
module tb_booth_wallace_mul_frac_pipe;
  import mul_frac_pkg::*;
  localparam int LANES = 4;

  typedef logic [LANES-1:0][W-1:0] vec_t;
  typedef struct packed {
    vec_t             q;
    logic [LANES-1:0] sat;
  } exp_t;

  logic clk, rst;
  logic rand_rdy, rdy_req, st_done;
  int   checks, failures, n_push, n_pop, n_drop, n_acc;
  exp_t sb[$];
  vec_t st_a[6], st_b[6];
  exp_t st_e[6];

  booth_wallace_mul_frac_pipe_if #(.LANES(LANES)) bus ();
  booth_wallace_mul_frac_pipe #(.LANES(LANES)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: exact integer product, optional +half-LSB, floor scale, clamp.
  function automatic exp_t calc(input vec_t a, input vec_t b, input logic s);
    exp_t   e;
    longint pa, pb, pr, r;
    e = '0;
    for (int i = 0; i < LANES; i++) begin
      pa = s ? longint'($signed(a[i])) : longint'(a[i]);
      pb = s ? longint'($signed(b[i])) : longint'(b[i]);
      pr = pa * pb;
`ifdef MUL_FRAC_ROUND_NEAREST_EN
      pr = pr + (64'sd1 <<< (FRAC_WIDTH-1));
`endif
      r = pr >>> FRAC_WIDTH;
      if (s && r > 32767) begin e.q[i] = 16'h7FFF; e.sat[i] = 1'b1; end
      else if (s && r < -32768) begin e.q[i] = 16'h8000; e.sat[i] = 1'b1; end
      else if (!s && r > 65535) begin e.q[i] = 16'hFFFF; e.sat[i] = 1'b1; end
      else e.q[i] = r[15:0];
    end
    return e;
  endfunction

  function automatic q_t rnd_op();
    q_t v;
    case ($urandom_range(0, 2))
      0: v = q_t'($urandom);
      1: begin
        v = q_t'($urandom_range(0, 2047));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
      default: case ($urandom_range(0, 5))
        0: v = 16'h0000; 1: v = 16'h0001; 2: v = 16'h7FFF;
        3: v = 16'h8000; 4: v = 16'hFFFF; default: v = 16'h0100;
      endcase
    endcase
    return v;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the rising edge that
  // follows the accepting falling edge, leaving in_valid high.
  task automatic send(input vec_t a, input vec_t b, input logic s, input exp_t e);
    bit acc;
    int n;
    bus.in_valid  = 1'b1;
    bus.in_signed = s;
    bus.in_a      = a;
    bus.in_b      = b;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      #1 acc = bus.in_ready;
      @(negedge clk);
      if (!acc) begin
        @(posedge clk);
        n++;
      end
    end
    if (acc) begin
      sb.push_back(e);
      n_push++;
      n_acc++;
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready stuck low");
    end
    @(posedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", sb.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  // out_ready driver: random or requested level, updated on rising edges.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_req;
    end
  end

  // Monitor: a result transfers on the next falling edge when valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst && bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got q=%h sat=%b", bus.out_result, bus.out_sat);
        end else begin
          e = sb.pop_front();
          n_pop++;
          if ({bus.out_result, bus.out_sat} !== {e.q, e.sat}) begin
            failures++;
            $display("FAIL result got q=%h sat=%b exp q=%h sat=%b",
                     bus.out_result, bus.out_sat, e.q, e.sat);
          end
        end
      end
    end
  end

  initial begin
    vec_t a, b, cap;
    exp_t e;
    int   acc0, pop0, n;
    checks = 0; failures = 0; n_push = 0; n_pop = 0; n_drop = 0; n_acc = 0;
    rand_rdy = 1'b0; rdy_req = 1'b1; st_done = 1'b0;
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_signed = 1'b0; bus.in_a = '0; bus.in_b = '0;

    #2;
    chk("reset_out_valid", bus.out_valid, 0);
    chk("reset_out_result", bus.out_result, 0);
    chk("reset_out_sat", bus.out_sat, 0);
    repeat (3) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("in_ready_after_reset", bus.in_ready, 1);

    // Latency: accept, then valid appears two falling edges later.
    a = {16'h9C00, 16'h6400, 16'hFE80, 16'h0180};
    b = {16'h0200, 16'h0200, 16'h0200, 16'h0200};
    e.q = {16'h8000, 16'h7FFF, 16'hFD00, 16'h0300}; e.sat = 4'b1100;
    send(a, b, 1'b1, e);
    bus.in_valid = 1'b0;
    #1 chk("latency_n0", bus.out_valid, 0);
    @(posedge clk);
    #1 chk("latency_n1", bus.out_valid, 0);
    @(posedge clk);
    #1 chk("latency_n2", bus.out_valid, 1);

    // Signed and unsigned boundaries, including the rounding-sensitive lanes.
    @(posedge clk);
    a = {16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001};
    b = {16'h8000, 16'h0100, 16'h0080, 16'h0080};
`ifdef MUL_FRAC_ROUND_NEAREST_EN
    e.q = {16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001};
`else
    e.q = {16'h7FFF, 16'h7FFF, 16'hFFFF, 16'h0000};
`endif
    e.sat = 4'b1000;
    send(a, b, 1'b1, e);
    a = {16'h0001, 16'hFFFF, 16'hC800, 16'hFE80};
    b = {16'h0080, 16'h0100, 16'h0200, 16'h0100};
`ifdef MUL_FRAC_ROUND_NEAREST_EN
    e.q = {16'h0001, 16'hFFFF, 16'hFFFF, 16'hFE80};
`else
    e.q = {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFE80};
`endif
    e.sat = 4'b0010;
    send(a, b, 1'b0, e);
    bus.in_valid = 1'b0;
    wait_drain();

    // Random traffic under random backpressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic s;
      for (int i = 0; i < LANES; i++) begin
        a[i] = rnd_op();
        b[i] = rnd_op();
      end
      s = 1'($urandom_range(0, 1));
      send(a, b, s, calc(a, b, s));
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
      end
    end
    bus.in_valid = 1'b0;
    rand_rdy = 1'b0;
    rdy_req  = 1'b1;
    wait_drain();

    // Stall: six bundles against a blocked output.
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < LANES; i++) begin
        st_a[k][i] = rnd_op();
        st_b[k][i] = rnd_op();
      end
      st_e[k] = calc(st_a[k], st_b[k], 1'b1);
    end
    rdy_req = 1'b0;
    repeat (2) @(posedge clk);
    acc0 = n_acc;
    pop0 = n_pop;
    fork
      begin
        for (int k = 0; k < 6; k++) send(st_a[k], st_b[k], 1'b1, st_e[k]);
        bus.in_valid = 1'b0;
        st_done = 1'b1;
      end
    join_none
    repeat (8) @(posedge clk);
    #3;
    chk("stall_accepts", n_acc - acc0, 3);
    chk("stall_in_ready", bus.in_ready, 0);
    chk("stall_out_valid", bus.out_valid, 1);
    chk("stall_head_result", {bus.out_result, bus.out_sat}, {st_e[0].q, st_e[0].sat});
    cap = bus.out_result;
    repeat (3) @(posedge clk);
    #3 chk("stall_hold", bus.out_result, cap);
    rdy_req = 1'b1;
    n = 0;
    while (!st_done && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("stream_done", st_done, 1);
    wait_drain();
    chk("stream_count", n_pop - pop0, 6);

    // Reset with two bundles in flight.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < LANES; i++) begin
        a[i] = rnd_op();
        b[i] = rnd_op();
      end
      send(a, b, 1'b0, calc(a, b, 1'b0));
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreset_out_valid", bus.out_valid, 0);
    chk("midreset_out_result", bus.out_result, 0);
    chk("midreset_out_sat", bus.out_sat, 0);
    n_drop += sb.size();
    sb.delete();
    repeat (2) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("post_reset_in_ready", bus.in_ready, 1);
    a = {16'h0300, 16'hFF00, 16'h0080, 16'h0180};
    b = {16'h0100, 16'h0200, 16'h0080, 16'h0200};
    send(a, b, 1'b1, calc(a, b, 1'b1));
    bus.in_valid = 1'b0;
    wait_drain();

    chk("scoreboard_balance", n_pop + n_drop, n_push);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
